// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared constants and helpers for the MAC tx frame arbiter
package eth_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_TERM = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // Beat injected to close a frame whose source stalled too long
  localparam logic [7:0] TERM_TDATA = 8'h00;
  localparam logic       TERM_TUSER = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/eth_arb_rr_select.sv
// rtl/eth_arb_rr_select.sv - combinational round-robin pick
// Returns the first requester above i_last, wrapping modulo S_COUNT.
module eth_arb_rr_select #(
  parameter int S_COUNT = 4,
  parameter int IDX_W   = 2
) (
  input  logic [S_COUNT-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_found
);

  localparam logic [IDX_W:0] COUNT_W = (IDX_W+1)'(S_COUNT);

  logic [IDX_W:0] w_sum;

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    o_index = '0;
    o_found = 1'b0;
    w_sum   = '0;
    for (int k = S_COUNT; k >= 1; k--) begin
      w_sum = {1'b0, i_last} + (IDX_W+1)'(k);
      if (w_sum >= COUNT_W) w_sum = w_sum - COUNT_W;
      if (i_req[w_sum[IDX_W-1:0]]) begin
        o_index = w_sum[IDX_W-1:0];
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_mac_tx_frame_arb.sv
// rtl/eth_mac_tx_frame_arb.sv - frame-level round-robin arbiter in front of the GMII MAC tx stream
// One frame at a time, registered output, stalled frames are force-terminated and the rest dropped.
module eth_mac_tx_frame_arb
  import eth_arb_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int STALL_TIMEOUT = 16,
  parameter int TIMEOUT_WIDTH = 8,
  localparam int IDX_W        = clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          cfg_enable,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_index,
  output logic                          stat_timeout
);

  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_grant_index;
  logic [IDX_W-1:0]         r_last_grant;
  logic                     r_grant_valid;
  logic [DATA_WIDTH-1:0]    r_tdata;
  logic                     r_tvalid;
  logic                     r_tlast;
  logic                     r_tuser;
  logic [TIMEOUT_WIDTH-1:0] r_stall_cnt;
  logic                     r_stat_timeout;

  logic [IDX_W-1:0]         w_sel_index;
  logic                     w_sel_found;
  logic                     w_out_free;
  logic                     w_g_valid;
  logic                     w_g_last;
  logic                     w_g_user;
  logic [DATA_WIDTH-1:0]    w_g_data;
  logic                     w_accept;
  logic                     w_term_load;
  logic                     w_stall_expire;

  eth_arb_rr_select #(
    .S_COUNT (S_COUNT),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .i_req   (s_axis_tvalid),
    .i_last  (r_last_grant),
    .o_index (w_sel_index),
    .o_found (w_sel_found)
  );

  assign w_out_free = m_axis_tready || !r_tvalid;

  always_comb begin
    w_g_valid     = 1'b0;
    w_g_last      = 1'b0;
    w_g_user      = 1'b0;
    w_g_data      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (r_grant_index == IDX_W'(i)) begin
        w_g_valid = s_axis_tvalid[i];
        w_g_last  = s_axis_tlast[i];
        w_g_user  = s_axis_tuser[i];
        w_g_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        if (r_state == ST_PASS) s_axis_tready[i] = w_out_free;
        else if (r_state == ST_DROP) s_axis_tready[i] = 1'b1;
      end
    end
  end

  assign w_accept       = (r_state == ST_PASS) && w_g_valid && w_out_free;
  assign w_term_load    = (r_state == ST_TERM) && w_out_free;
  assign w_stall_expire = (STALL_TIMEOUT != 0) &&
                          (r_stall_cnt == TIMEOUT_WIDTH'(STALL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_grant_index  <= '0;
      r_last_grant   <= IDX_W'(S_COUNT - 1);
      r_grant_valid  <= 1'b0;
      r_tdata        <= '0;
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_tuser        <= 1'b0;
      r_stall_cnt    <= '0;
      r_stat_timeout <= 1'b0;
    end else begin
      r_stat_timeout <= w_term_load;

      if (w_accept) begin
        r_tdata  <= w_g_data;
        r_tvalid <= 1'b1;
        r_tlast  <= w_g_last;
        r_tuser  <= w_g_user;
      end else if (w_term_load) begin
        r_tdata  <= DATA_WIDTH'(TERM_TDATA);
        r_tvalid <= 1'b1;
        r_tlast  <= 1'b1;
        r_tuser  <= TERM_TUSER;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (cfg_enable && w_sel_found) begin
            r_grant_index <= w_sel_index;
            r_last_grant  <= w_sel_index;
            r_grant_valid <= 1'b1;
            r_stall_cnt   <= '0;
            r_state       <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (w_g_valid) begin
            r_stall_cnt <= '0;
            if (w_accept && w_g_last) begin
              r_grant_valid <= 1'b0;
              r_state       <= ST_IDLE;
            end
          end else if (w_out_free) begin
            // A full output register means the MAC is the one stalling, not the source
            if (w_stall_expire) begin
              r_stall_cnt <= '0;
              r_state     <= ST_TERM;
            end else begin
              r_stall_cnt <= r_stall_cnt + 1'b1;
            end
          end
        end
        ST_TERM: begin
          if (w_term_load) r_state <= ST_DROP;
        end
        default: begin
          if (w_g_valid && w_g_last) begin
            r_grant_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign grant_valid   = r_grant_valid;
  assign grant_index   = r_grant_index;
  assign stat_timeout  = r_stat_timeout;

endmodule

// File: doc/eth_mac_tx_frame_arb.md
Name: eth_mac_tx_frame_arb

Overview:
- Frame-level round-robin arbiter that shares the single 8-bit transmit AXI-stream input of the 1G GMII MAC between S_COUNT requesters.
- Grants one source per frame, forwards it through one output register stage, and never interleaves frames.
- Terminates a frame whose source stalls mid-frame too long: emits an error-marked last beat, then discards that source's remaining beats.
- Sits in the MAC tx clock domain, directly in front of the MAC's tx_axis port.

Parameters:
S_COUNT, 4, number of requesting sources (2..16)
DATA_WIDTH, 8, beat width; fixed at 8 for the GMII MAC
STALL_TIMEOUT, 16, consecutive idle cycles of the granted source mid-frame before forced termination; 0 disables
TIMEOUT_WIDTH, 8, width of the stall counter; must hold STALL_TIMEOUT

Ports:
clk  in  1  tx clock (MAC tx_clk)
rst_n  in  1  reset
s_axis_tdata  in  S_COUNT*DATA_WIDTH  source data, source i at [i*8+:8]
s_axis_tvalid  in  S_COUNT  per-source valid
s_axis_tready  out  S_COUNT  per-source ready
s_axis_tlast  in  S_COUNT  per-source last
s_axis_tuser  in  S_COUNT  per-source error/abort flag
m_axis_tdata  out  DATA_WIDTH  to MAC tx_axis_tdata
m_axis_tvalid  out  1  to MAC
m_axis_tready  in  1  from MAC
m_axis_tlast  out  1  to MAC
m_axis_tuser  out  1  to MAC
cfg_enable  in  1  allow new grants
grant_valid  out  1  a frame is in progress (PASS or DROP)
grant_index  out  $clog2(S_COUNT)  source currently or most recently granted
stat_timeout  out  1  one-cycle pulse on forced termination

Behaviour:
- Single clock clk. Reset is synchronous and active-low (rst_n).
- Reset values: m_axis_tvalid/tlast/tuser 0; tdata 0; s_axis_tready all 0; grant_valid 0; grant_index 0; stat_timeout 0; state IDLE; last-grant pointer S_COUNT-1, so source 0 has first priority; stall counter 0.
- Reset asserted mid-frame: frame abandoned, no termination beat, output register cleared.

State machine (IDLE, PASS, TERM, DROP):
- IDLE
  - If cfg_enable && |s_axis_tvalid: select the first valid source scanning upward from last_grant+1, wrapping modulo S_COUNT.
  - Register it as grant_index and update last_grant; grant_valid=1; go to PASS.
  - Arbitration latency is 1 cycle. No tready is asserted in IDLE.
- PASS
  - s_axis_tready[g] = (m_axis_tready || !m_axis_tvalid); all other readys are 0.
  - An accepted beat loads the output register with tdata/tlast/tuser.
  - Accepted beat with tlast: go to IDLE, grant_valid=0. The next grant is evaluated in IDLE, so there is a minimum of one idle cycle between frames.
  - Output register: m_axis_tvalid clears when m_axis_tready && no new beat is loaded that cycle.
- Stall counter (PASS only)
  - Increments each cycle !s_axis_tvalid[g]; clears on any valid beat.
  - When it reaches STALL_TIMEOUT (and STALL_TIMEOUT != 0): go to TERM.
  - Never counts during output backpressure (tvalid high, tready low).
- TERM
  - When the output register is free (m_axis_tready || !m_axis_tvalid): load tdata=0, tlast=1, tuser=1 and pulse stat_timeout.
  - Then go to DROP.
  - If the source reasserts tvalid in the same cycle TERM is entered, it is not accepted; termination wins.
- DROP
  - s_axis_tready[g]=1; beats are discarded and not forwarded.
  - Discarded beat with tlast: go to IDLE, grant_valid=0.
- cfg_enable deasserted: blocks only new grants; the frame in progress completes normally.
- Source tuser: forwarded unchanged.
- Source dropping tvalid mid-frame below the timeout: tolerated; the MAC flags underflow itself.

Decomposition:
- Shared package eth_arb_pkg:
  - state encoding constants ST_IDLE/ST_PASS/ST_TERM/ST_DROP (2 bits)
  - clog2 function
  - TERM beat constants (data 8'h00, tuser 1)
- Sub-module eth_arb_rr_select: combinational round-robin pick. Inputs: request vector, last pointer. Outputs: index, found.
- Top holds the FSM, stall counter and output register. Expected size: 150–250 lines total.

Test Plan:
- Sources 0 and 2 each hold a 3-beat frame at reset release, MAC always ready -> output is source 0 frame (grant_index=0), one idle cycle, then source 2 frame; tlast on beats 3 and 6.
- All 4 sources continuously valid with 2-beat frames, 8 frames -> grant_index sequence 0,1,2,3,0,1,2,3; no interleaving.
- Source 1 mid-frame, m_axis_tready held low 40 cycles -> no timeout, no stat_timeout, data stable, transfer resumes unchanged.
- STALL_TIMEOUT=16, source 3 sends 2 beats then tvalid=0 for 16 cycles -> output beat 0x00 with tlast=1, tuser=1; stat_timeout pulses once; remaining 5 beats of source 3 consumed with no output; IDLE after their tlast.
- cfg_enable=0 while source 0 is mid-frame and source 1 pending -> source 0 completes; source 1 not granted until cfg_enable=1, then granted 1 cycle later.
- rst_n low for 1 cycle mid-frame -> next cycle all outputs at reset values; after release, source 0 has priority again.
